// File: rtl/btc_result_collector_if.sv
// Result-side handshake of the nonce collector: show-ahead head entry plus pop strobe.
// res_core exists only when BTC_COLLECT_CORE_ID_EN is defined.
`ifdef BTC_COLLECT_CORE_ID_EN
interface btc_result_collector_if #(parameter int CID_W = 3);
    logic             res_valid;
    logic [31:0]      res_nonce;
    logic [CID_W-1:0] res_core;
    logic             res_pop;

    modport master (output res_valid, output res_nonce, output res_core, input res_pop);
    modport slave  (input res_valid, input res_nonce, input res_core, output res_pop);
endinterface
`else
interface btc_result_collector_if;
    logic        res_valid;
    logic [31:0] res_nonce;
    logic        res_pop;

    modport master (output res_valid, output res_nonce, input res_pop);
    modport slave  (input res_valid, input res_nonce, output res_pop);
endinterface
`endif

// File: rtl/btc_result_collector.sv
// Per-core nonce capture, round-robin arbitration into a show-ahead FIFO; find-to-res_valid 2 cycles.
// A full FIFO holds finds in per-core pending slots (never lost); a second find on a pending core sets overflow. Option: BTC_COLLECT_CORE_ID_EN.
module btc_result_collector #(
    parameter int NUM_CORES  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [NUM_CORES-1:0]    core_found_i,
    input  logic [32*NUM_CORES-1:0] core_nonce_i,
    input  logic [NUM_CORES-1:0]    core_done_i,
    btc_result_collector_if.master  res,
    output logic [15:0]             found_count_o,
    output logic                    overflow_o,
    output logic                    all_done_o,
    output logic                    busy_o
);

    localparam int CID_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
`ifdef BTC_COLLECT_CORE_ID_EN
    localparam int ENTRY_W = 32 + CID_W;
`else
    localparam int ENTRY_W = 32;
`endif

    logic [NUM_CORES-1:0]         found_q,      found_d;
    logic [NUM_CORES-1:0]         pending_q,    pending_d;
    logic [NUM_CORES-1:0][31:0]   cap_q,        cap_d;
    logic [CID_W-1:0]             last_grant_q, last_grant_d;
    logic [PTR_W-1:0]             wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q,     rd_ptr_d;
    logic [CNT_W-1:0]             fifo_cnt_q,   fifo_cnt_d;
    logic [15:0]                  found_cnt_q,  found_cnt_d;
    logic                         overflow_q,   overflow_d;
    logic                         all_done_q,   all_done_d;
    logic                         busy_q,       busy_d;
    logic                         start_dly_q,  start_dly_d;
    logic [ENTRY_W-1:0]           mem_q [FIFO_DEPTH];

    logic [NUM_CORES-1:0] edge_c;
    logic                 pop_c, can_push_c, push_c, grant_vld_c, grant_hit_c;
    logic [CID_W-1:0]     grant_idx_c, cand_c;
    logic [ENTRY_W-1:0]   push_dat_c, head_c;

    always_comb begin
        edge_c      = start_i ? '0 : (core_found_i & ~found_q);
        pop_c       = res.res_pop && (fifo_cnt_q != '0);
        can_push_c  = (fifo_cnt_q != CNT_W'(FIFO_DEPTH)) || pop_c;

        // Round-robin: first pending core strictly after the last grant, wrapping.
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        cand_c      = '0;
        for (int off = 1; off <= NUM_CORES; off++) begin
            cand_c = CID_W'((int'(last_grant_q) + off) % NUM_CORES);
            if (!grant_vld_c && pending_q[cand_c]) begin
                grant_vld_c = 1'b1;
                grant_idx_c = cand_c;
            end
        end
        push_c = grant_vld_c && can_push_c && !start_i;

`ifdef BTC_COLLECT_CORE_ID_EN
        push_dat_c = {grant_idx_c, cap_q[grant_idx_c]};
`else
        push_dat_c = cap_q[grant_idx_c];
`endif

        found_d     = core_found_i;
        pending_d   = pending_q;
        cap_d       = cap_q;
        overflow_d  = overflow_q;
        grant_hit_c = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            grant_hit_c = push_c && (grant_idx_c == CID_W'(i));
            if (grant_hit_c) begin
                pending_d[i] = 1'b0;
            end
            // A grant in the same cycle frees the slot, so the new find re-captures.
            if (edge_c[i]) begin
                if (pending_q[i] && !grant_hit_c) begin
                    overflow_d = 1'b1;
                end else begin
                    pending_d[i] = 1'b1;
                    cap_d[i]     = core_nonce_i[32*i +: 32];
                end
            end
        end

        last_grant_d = push_c ? grant_idx_c : last_grant_q;
        wr_ptr_d     = wr_ptr_q + PTR_W'(push_c);
        rd_ptr_d     = rd_ptr_q + PTR_W'(pop_c);
        fifo_cnt_d   = fifo_cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
        found_cnt_d  = (push_c && (found_cnt_q != 16'hFFFF)) ? found_cnt_q + 16'd1 : found_cnt_q;

        // Masked for two cycles after start so done levels left over from the previous job are ignored.
        all_done_d  = (start_i || start_dly_q) ? 1'b0
                    : (all_done_q || ((&core_done_i) && !(|pending_q) && busy_q));
        busy_d      = start_i || (busy_q && !all_done_q);
        start_dly_d = start_i;

        if (start_i) begin
            pending_d    = '0;
            cap_d        = '0;
            overflow_d   = 1'b0;
            last_grant_d = CID_W'(NUM_CORES - 1);
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            fifo_cnt_d   = '0;
            found_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            found_q      <= '0;
            pending_q    <= '0;
            cap_q        <= '0;
            last_grant_q <= CID_W'(NUM_CORES - 1);
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
            found_cnt_q  <= '0;
            overflow_q   <= 1'b0;
            all_done_q   <= 1'b0;
            busy_q       <= 1'b0;
            start_dly_q  <= 1'b0;
        end else begin
            found_q      <= found_d;
            pending_q    <= pending_d;
            cap_q        <= cap_d;
            last_grant_q <= last_grant_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_cnt_q   <= fifo_cnt_d;
            found_cnt_q  <= found_cnt_d;
            overflow_q   <= overflow_d;
            all_done_q   <= all_done_d;
            busy_q       <= busy_d;
            start_dly_q  <= start_dly_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= push_dat_c;
        end
    end

    assign head_c        = mem_q[rd_ptr_q];
    assign res.res_valid = (fifo_cnt_q != '0);
    assign res.res_nonce = res.res_valid ? head_c[31:0] : 32'd0;
`ifdef BTC_COLLECT_CORE_ID_EN
    assign res.res_core  = res.res_valid ? head_c[32 +: CID_W] : '0;
`endif
    assign found_count_o = found_cnt_q;
    assign overflow_o    = overflow_q;
    assign all_done_o    = all_done_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_btc_result_collector.sv
// Directed bench for btc_result_collector (8 cores, 4-entry FIFO).
module tb_btc_result_collector;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [7:0]   core_found;
    logic [255:0] core_nonce;
    logic [7:0]   core_done;
    logic [15:0]  found_count;
    logic         overflow, all_done, busy;

    int vec_cnt = 0;
    int err_cnt = 0;

`ifdef BTC_COLLECT_CORE_ID_EN
    btc_result_collector_if #(.CID_W(3)) rif();
`else
    btc_result_collector_if rif();
`endif

    btc_result_collector #(.NUM_CORES(8), .FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .core_found_i  (core_found),
        .core_nonce_i  (core_nonce),
        .core_done_i   (core_done),
        .res           (rif.master),
        .found_count_o (found_count),
        .overflow_o    (overflow),
        .all_done_o    (all_done),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nonce(input int i, input logic [31:0] v);
        core_nonce[32*i +: 32] = v;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; core_found = '0; core_nonce = '0; core_done = '0; rif.res_pop = 1'b0;
        tick(); tick();
        vec_cnt++; if (rif.res_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid got=%b exp=0", rif.res_valid); end
        vec_cnt++; if (rif.res_nonce !== 32'd0) begin err_cnt++; $display("FAIL reset_nonce got=%h exp=0", rif.res_nonce); end
        vec_cnt++; if (found_count !== 16'd0) begin err_cnt++; $display("FAIL reset_count got=%0d exp=0", found_count); end
        vec_cnt++; if ({overflow, all_done, busy} !== 3'b000) begin err_cnt++; $display("FAIL reset_flags got=%b exp=000", {overflow, all_done, busy}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_find();
        do_start();
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL single_busy got=%b exp=1", busy); end
        set_nonce(3, 32'h6000_1234);
        core_found[3] = 1'b1;
        tick();
        vec_cnt++; if (rif.res_valid !== 1'b0) begin err_cnt++; $display("FAIL single_t1_valid got=%b exp=0", rif.res_valid); end
        tick();
        vec_cnt++; if (rif.res_valid !== 1'b1) begin err_cnt++; $display("FAIL single_t2_valid got=%b exp=1", rif.res_valid); end
        vec_cnt++; if (rif.res_nonce !== 32'h6000_1234) begin err_cnt++; $display("FAIL single_nonce got=%h exp=60001234", rif.res_nonce); end
`ifdef BTC_COLLECT_CORE_ID_EN
        vec_cnt++; if (rif.res_core !== 3'd3) begin err_cnt++; $display("FAIL single_core got=%0d exp=3", rif.res_core); end
`endif
        vec_cnt++; if (found_count !== 16'd1) begin err_cnt++; $display("FAIL single_count got=%0d exp=1", found_count); end
        rif.res_pop = 1'b1;
        tick();
        rif.res_pop = 1'b0;
        core_found = '0;
        vec_cnt++; if (rif.res_valid !== 1'b0) begin err_cnt++; $display("FAIL single_pop_valid got=%b exp=0", rif.res_valid); end
        tick();
    endtask

    task automatic test_simultaneous();
        logic [31:0] exp_a [3];
        logic [31:0] exp_b [2];
        exp_a[0] = 32'hA000_0000; exp_a[1] = 32'hA000_0002; exp_a[2] = 32'hA000_0005;
        exp_b[0] = 32'hB000_0000; exp_b[1] = 32'hB000_0005;
        do_start();
        set_nonce(0, exp_a[0]); set_nonce(2, exp_a[1]); set_nonce(5, exp_a[2]);
        core_found = 8'b0010_0101;
        rif.res_pop = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            vec_cnt++; if (rif.res_valid !== 1'b1 || rif.res_nonce !== exp_a[k]) begin err_cnt++; $display("FAIL simul_a%0d got=%b/%h exp=1/%h", k, rif.res_valid, rif.res_nonce, exp_a[k]); end
        end
        core_found = '0;
        tick();
        vec_cnt++; if (rif.res_valid !== 1'b0) begin err_cnt++; $display("FAIL simul_a_empty got=%b exp=0", rif.res_valid); end
        // last grant was core 5, so core 0 must still win over core 5 after the wrap
        set_nonce(0, exp_b[0]); set_nonce(5, exp_b[1]);
        core_found = 8'b0010_0001;
        tick();
        for (int k = 0; k < 2; k++) begin
            tick();
            vec_cnt++; if (rif.res_valid !== 1'b1 || rif.res_nonce !== exp_b[k]) begin err_cnt++; $display("FAIL simul_b%0d got=%b/%h exp=1/%h", k, rif.res_valid, rif.res_nonce, exp_b[k]); end
        end
        tick();
        vec_cnt++; if (rif.res_valid !== 1'b0) begin err_cnt++; $display("FAIL simul_b_empty got=%b exp=0", rif.res_valid); end
        vec_cnt++; if (found_count !== 16'd5) begin err_cnt++; $display("FAIL simul_count got=%0d exp=5", found_count); end
        rif.res_pop = 1'b0;
        core_found = '0;
        tick();
    endtask

    task automatic test_full_fifo();
        do_start();
        for (int i = 0; i < 6; i++) set_nonce(i, 32'hC000_0000 + 32'(i));
        core_found = 8'h3F;
        for (int k = 0; k < 7; k++) tick();
        vec_cnt++; if (found_count !== 16'd4) begin err_cnt++; $display("FAIL full_count4 got=%0d exp=4", found_count); end
        vec_cnt++; if (overflow !== 1'b0) begin err_cnt++; $display("FAIL full_overflow got=%b exp=0", overflow); end
        rif.res_pop = 1'b1;
        for (int k = 0; k < 6; k++) begin
            vec_cnt++; if (rif.res_valid !== 1'b1 || rif.res_nonce !== 32'hC000_0000 + 32'(k)) begin err_cnt++; $display("FAIL full_head%0d got=%b/%h exp=1/%h", k, rif.res_valid, rif.res_nonce, 32'hC000_0000 + 32'(k)); end
            tick();
        end
        rif.res_pop = 1'b0;
        vec_cnt++; if (rif.res_valid !== 1'b0) begin err_cnt++; $display("FAIL full_empty got=%b exp=0", rif.res_valid); end
        vec_cnt++; if (found_count !== 16'd6) begin err_cnt++; $display("FAIL full_count6 got=%0d exp=6", found_count); end
        vec_cnt++; if (overflow !== 1'b0) begin err_cnt++; $display("FAIL full_overflow_end got=%b exp=0", overflow); end
        core_found = '0;
        tick();
    endtask

    task automatic test_loss();
        logic [31:0] exp_q [5];
        exp_q[0] = 32'hE000_0000; exp_q[1] = 32'hE000_0002; exp_q[2] = 32'hE000_0003;
        exp_q[3] = 32'hE000_0004; exp_q[4] = 32'hD000_0001;
        do_start();
        set_nonce(0, exp_q[0]); set_nonce(2, exp_q[1]); set_nonce(3, exp_q[2]); set_nonce(4, exp_q[3]);
        core_found = 8'b0001_1101;
        for (int k = 0; k < 6; k++) tick();
        set_nonce(1, exp_q[4]);
        core_found[1] = 1'b1;
        tick();
        core_found[1] = 1'b0;
        tick();
        vec_cnt++; if (overflow !== 1'b0) begin err_cnt++; $display("FAIL loss_pre_overflow got=%b exp=0", overflow); end
        set_nonce(1, 32'hD000_0002);
        core_found[1] = 1'b1;
        tick();
        vec_cnt++; if (overflow !== 1'b1) begin err_cnt++; $display("FAIL loss_overflow got=%b exp=1", overflow); end
        rif.res_pop = 1'b1;
        for (int k = 0; k < 5; k++) begin
            vec_cnt++; if (rif.res_valid !== 1'b1 || rif.res_nonce !== exp_q[k]) begin err_cnt++; $display("FAIL loss_head%0d got=%b/%h exp=1/%h", k, rif.res_valid, rif.res_nonce, exp_q[k]); end
            tick();
        end
        vec_cnt++; if (rif.res_valid !== 1'b0) begin err_cnt++; $display("FAIL loss_second_absent got=%b/%h exp=0", rif.res_valid, rif.res_nonce); end
        vec_cnt++; if (found_count !== 16'd5) begin err_cnt++; $display("FAIL loss_count got=%0d exp=5", found_count); end
        rif.res_pop = 1'b0;
        core_found = '0;
        tick();
    endtask

    task automatic test_completion();
        do_start();
        core_done = 8'h7F;
        tick(); tick();
        vec_cnt++; if (all_done !== 1'b0) begin err_cnt++; $display("FAIL done_partial got=%b exp=0", all_done); end
        core_done = 8'hFF;
        tick();
        vec_cnt++; if (all_done !== 1'b1 || busy !== 1'b1) begin err_cnt++; $display("FAIL done_t1 got=%b%b exp=11", all_done, busy); end
        tick();
        vec_cnt++; if (all_done !== 1'b1 || busy !== 1'b0) begin err_cnt++; $display("FAIL done_t2 got=%b%b exp=10", all_done, busy); end
        start = 1'b1;
        tick();
        start = 1'b0;
        vec_cnt++; if (all_done !== 1'b0 || busy !== 1'b1) begin err_cnt++; $display("FAIL restart_c1 got=%b%b exp=01", all_done, busy); end
        tick();
        vec_cnt++; if (all_done !== 1'b0) begin err_cnt++; $display("FAIL restart_c2 got=%b exp=0", all_done); end
        tick();
        vec_cnt++; if (all_done !== 1'b1) begin err_cnt++; $display("FAIL restart_c3 got=%b exp=1", all_done); end
        core_done = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_start();
        set_nonce(0, 32'hF000_0000); set_nonce(1, 32'hF000_0001); set_nonce(2, 32'hF000_0002);
        core_found = 8'b0000_0111;
        for (int k = 0; k < 5; k++) tick();
        vec_cnt++; if (rif.res_valid !== 1'b1 || found_count !== 16'd3) begin err_cnt++; $display("FAIL rstmid_pre got=%b/%0d exp=1/3", rif.res_valid, found_count); end
        rst = 1'b1;
        core_found = '0;
        tick();
        vec_cnt++; if (rif.res_valid !== 1'b0 || rif.res_nonce !== 32'd0) begin err_cnt++; $display("FAIL rstmid_res got=%b/%h exp=0/0", rif.res_valid, rif.res_nonce); end
`ifdef BTC_COLLECT_CORE_ID_EN
        vec_cnt++; if (rif.res_core !== 3'd0) begin err_cnt++; $display("FAIL rstmid_core got=%0d exp=0", rif.res_core); end
`endif
        vec_cnt++; if (found_count !== 16'd0) begin err_cnt++; $display("FAIL rstmid_count got=%0d exp=0", found_count); end
        vec_cnt++; if ({overflow, all_done, busy} !== 3'b000) begin err_cnt++; $display("FAIL rstmid_flags got=%b exp=000", {overflow, all_done, busy}); end
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_find();
        test_simultaneous();
        test_full_fifo();
        test_loss();
        test_completion();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
